md_unit: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline with precise exceptions. It consumes the E-stage instruction and operands registered by the D/E pipeline register and executes mult/multu/div/divu over several cycles. It holds the HI/LO architectural registers, serves mfhi/mflo/mthi/mtlo, and raises a stall request to the hazard unit while an operation is in flight.

---
 rtl/md_unit.sv | 162 ++++++++++++++++
 tb/tb_md_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Holds the HI/LO architectural registers, serves mfhi/mflo/mthi/mtlo and
// requests a pipeline stall while an arithmetic operation is in flight.
// Handshake: an arithmetic op issues (start) when it sits in E, the unit is
// idle and no exception is being taken; busy then stays high until HI/LO
// carry the final result, and stall_md holds any md instruction in D back.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic [31:0] IR_D,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out,
  output logic        stall_md
);

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_hi_q, hold_hi_d;
  logic [31:0] hold_lo_q, hold_lo_d;
  logic        hold_we_q, hold_we_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        e_r, d_r;
  logic        is_mult, is_multu, is_div, is_divu, is_arith;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, d_is_md;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, uq, ur, quo_s, rem_s;
  logic [31:0] divu_b, quo_u, rem_u;

  // Decode of the E and D stage instructions
  always_comb begin
    e_r      = (IR_E[31:26] == 6'b000000);
    d_r      = (IR_D[31:26] == 6'b000000);
    is_mult  = e_r && (IR_E[5:0] == F_MULT);
    is_multu = e_r && (IR_E[5:0] == F_MULTU);
    is_div   = e_r && (IR_E[5:0] == F_DIV);
    is_divu  = e_r && (IR_E[5:0] == F_DIVU);
    is_mfhi  = e_r && (IR_E[5:0] == F_MFHI);
    is_mflo  = e_r && (IR_E[5:0] == F_MFLO);
    is_mthi  = e_r && (IR_E[5:0] == F_MTHI);
    is_mtlo  = e_r && (IR_E[5:0] == F_MTLO);
    is_arith = is_mult || is_multu || is_div || is_divu;
    d_is_md  = d_r && (IR_D[5:3] == 3'b010 || IR_D[5:3] == 3'b011);
  end

  // Full-width results; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0
  always_comb begin
    prod_s = {{32{RS_E[31]}}, RS_E} * {{32{RT_E[31]}}, RT_E};
    prod_u = {32'd0, RS_E} * {32'd0, RT_E};
    abs_a  = RS_E[31] ? (32'd0 - RS_E) : RS_E;
    abs_b  = RT_E[31] ? (32'd0 - RT_E) : RT_E;
    div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq     = abs_a / div_b;
    ur     = abs_a % div_b;
    quo_s  = (RS_E[31] ^ RT_E[31]) ? (32'd0 - uq) : uq;
    rem_s  = RS_E[31] ? (32'd0 - ur) : ur;
    divu_b = (RT_E == 32'd0) ? 32'd1 : RT_E;
    quo_u  = RS_E / divu_b;
    rem_u  = RS_E % divu_b;
  end

  assign busy     = (state_q == RUN);
  assign start    = is_arith && !busy && !cancel;
  assign stall_md = d_is_md && (start || busy);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign md_out   = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

  // Next-state: issue, countdown, final HI/LO write and mthi/mtlo
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_hi_d = hold_hi_q;
    hold_lo_d = hold_lo_q;
    hold_we_d = hold_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = (is_div || is_divu) ? DIV_CYC : MULT_CYC;
          hold_we_d = !((is_div || is_divu) && (RT_E == 32'd0));
          if (is_mult) begin
            hold_hi_d = prod_s[63:32];
            hold_lo_d = prod_s[31:0];
          end else if (is_multu) begin
            hold_hi_d = prod_u[63:32];
            hold_lo_d = prod_u[31:0];
          end else if (is_div) begin
            hold_hi_d = rem_s;
            hold_lo_d = quo_s;
          end else begin
            hold_hi_d = rem_u;
            hold_lo_d = quo_u;
          end
        end else if (!cancel) begin
          if (is_mthi) hi_d = RS_E;
          if (is_mtlo) lo_d = RS_E;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (hold_we_q) begin
            hi_d = hold_hi_q;
            lo_d = hold_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hold_hi_q <= 32'd0;
      hold_lo_q <= 32'd0;
      hold_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      hold_we_q <= hold_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against a behavioural
// HI/LO model, with expected results queued at issue and popped at completion.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [31:0] IR_E, RS_E, RT_E, IR_D;
  logic        cancel;
  logic        start, busy, stall_md;
  logic [31:0] HI, LO, md_out;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [31:0] NOP    = 32'd0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  int errors = 0;
  int checks = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .IR_E(IR_E), .RS_E(RS_E), .RT_E(RT_E),
    .IR_D(IR_D), .cancel(cancel), .start(start), .busy(busy), .HI(HI),
    .LO(LO), .md_out(md_out), .stall_md(stall_md)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, f};
  endfunction

  function automatic logic is_md_instr(input logic [31:0] ir);
    logic [5:0] f;
    f = ir[5:0];
    return (ir[31:26] == 6'd0) &&
           (f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO ||
            f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
  endfunction

  // Reference model: returns {HI, LO} after the op given current HI/LO
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return 64'({32'd0, a}) * 64'({32'd0, b});
      F_DIV: begin
        if (b == 32'd0) return {m_hi, m_lo};
        q = sa / sb; r = sa % sb;
        qv = 64'(q); rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 32'd0) return {m_hi, m_lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one arithmetic op with ird in D; follow it to completion
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ird, input int cyc);
    logic [63:0] got;
    logic        exp_stall;
    int          n;
    logic        done;
    @(posedge clk); #1;
    IR_E = rtype(f); RS_E = a; RT_E = b; IR_D = ird; cancel = 1'b0;
    #1;
    exp_stall = is_md_instr(ird);
    check("start_issue", start, 1'b1);
    check("busy_issue", busy, 1'b0);
    check("stall_issue", stall_md, exp_stall);
    exp_q.push_back(model(f, a, b));
    n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      IR_E = NOP;
      #1;
      if (busy) begin
        n++;
        check("stall_busy", stall_md, exp_stall);
      end else begin
        done = 1'b1;
      end
    end
    check("busy_cycles", n, cyc);
    check("stall_after", stall_md, 1'b0);
    got = exp_q.pop_front();
    check("hi_result", HI, got[63:32]);
    check("lo_result", LO, got[31:0]);
    m_hi = got[63:32];
    m_lo = got[31:0];
  endtask

  // mthi/mtlo with a given cancel value
  task automatic move_to(input logic [5:0] f, input logic [31:0] val, input logic c);
    @(posedge clk); #1;
    IR_E = rtype(f); RS_E = val; cancel = c; IR_D = NOP;
    @(posedge clk); #1;
    IR_E = NOP; cancel = 1'b0;
    if (!c) begin
      if (f == F_MTHI) m_hi = val; else m_lo = val;
    end
    #1;
    check("mt_hi", HI, m_hi);
    check("mt_lo", LO, m_lo);
  endtask

  initial begin
    reset = 1'b1; IR_E = NOP; RS_E = '0; RT_E = '0; IR_D = NOP; cancel = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", start, 1'b0);
    check("rst_stall", stall_md, 1'b0);

    // mult -2 * 3 with mflo waiting in D, then mflo reaches E
    run_op(F_MULT, 32'hFFFFFFFE, 32'h3, rtype(F_MFLO), 5);
    check("mult_hi_const", HI, 32'hFFFFFFFF);
    check("mult_lo_const", LO, 32'hFFFFFFFA);
    IR_E = rtype(F_MFLO); IR_D = NOP; #1;
    check("mflo_out", md_out, m_lo);
    IR_E = rtype(F_MFHI); #1;
    check("mfhi_out", md_out, m_hi);

    // multu with an addu in D: never stalled
    run_op(F_MULTU, 32'hFFFFFFFE, 32'h3, rtype(F_ADDU), 5);
    check("multu_hi_const", HI, 32'h00000002);

    // div -7 / 2, then divu by zero leaves HI/LO alone
    run_op(F_DIV, 32'hFFFFFFF9, 32'h2, NOP, 10);
    check("div_lo_const", LO, 32'hFFFFFFFD);
    check("div_hi_const", HI, 32'hFFFFFFFF);
    run_op(F_DIVU, 32'h7, 32'h0, rtype(F_MTHI), 10);
    check("divz_hi_kept", HI, 32'hFFFFFFFF);

    // overflow case
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, NOP, 10);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h0);

    // random operations
    for (int i = 0; i < 8; i++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(0, 1) ? $urandom : $urandom_range(1, 100);
      run_op(f, a, b, ($urandom_range(0, 1) != 0) ? rtype(F_MFHI) : NOP,
             (f == F_DIV || f == F_DIVU) ? 10 : 5);
    end

    // mthi/mtlo with and without cancel
    move_to(F_MTHI, 32'h12345678, 1'b0);
    check("mthi_const", HI, 32'h12345678);
    move_to(F_MTHI, 32'hDEADBEEF, 1'b1);
    move_to(F_MTLO, 32'hCAFEF00D, 1'b0);
    move_to(F_MTLO, 32'h0BADF00D, 1'b1);

    // mult under cancel never issues
    @(posedge clk); #1;
    IR_E = rtype(F_MULT); RS_E = 32'd9; RT_E = 32'd9; cancel = 1'b1; IR_D = rtype(F_MFLO);
    #1;
    check("cancel_start", start, 1'b0);
    check("cancel_stall", stall_md, 1'b0);
    @(posedge clk); #1;
    IR_E = NOP; cancel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("cancel_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    check("cancel_hi", HI, m_hi);
    check("cancel_lo", LO, m_lo);

    // reset during cycle t+3 of a div: discarded, no late write
    @(posedge clk); #1;
    IR_E = rtype(F_DIV); RS_E = 32'd100; RT_E = 32'd7; IR_D = NOP;
    @(posedge clk); #1;
    IR_E = NOP;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    m_hi = '0; m_lo = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", HI, 32'd0);
    check("mid_rst_lo", LO, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("late_busy", busy, 1'b0);
    check("late_hi", HI, m_hi);
    check("late_lo", LO, m_lo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
